// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul scratchpad slice.
// Provides derived-size helpers, the scratchpad target width and the
// read-sequencer state encoding.
package matmul_pkg;

    // Scratchpad target select width.
    localparam int unsigned SP_TGT_W = 2;

    // Maximum matrix dimension: how many elements fit in one bus entry.
    function automatic int unsigned calc_max_dim(input int unsigned bus_width,
                                                 input int unsigned data_width);
        return bus_width / data_width;
    endfunction

    // Scratchpad address width: row and column index side by side.
    function automatic int unsigned calc_aw(input int unsigned max_dim);
        return 2 * $clog2(max_dim);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sp_rd_state_t;

endpackage

// File: rtl/sp_rd_out_stage.sv
// One-entry output register for the scratchpad read stream.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   flush                   drop the held beat (abort)
//   load, load_data/last    capture a new beat; only asserted when slot_free
//   ready_i                 downstream ready
//   valid, data, last       registered stream outputs
//   slot_free               register empty or being emptied this cycle
module sp_rd_out_stage #(
    parameter int unsigned BUS_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush,
    input  logic                 load,
    input  logic [BUS_WIDTH-1:0] load_data,
    input  logic                 load_last,
    input  logic                 ready_i,
    output logic                 valid,
    output logic [BUS_WIDTH-1:0] data,
    output logic                 last,
    output logic                 slot_free
);

    assign slot_free = !valid || ready_i;

    // Load wins over accept: a load in the accept cycle replaces the beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (valid && ready_i) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sp_reader.sv
// Read-side sequencer for the result scratchpad.
// Walks one target matrix row-major and streams each entry out on a
// valid/ready interface with a last flag. Fetches stall while the matmul
// engine writes the scratchpad (read data is zero during writes).
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   start_i, abort_i                  control; start sampled only in IDLE
//   target_i, rows_m1_i, cols_m1_i    transfer setup, latched at start
//   busy_o, done_o                    status
//   sp_mode_o, sp_read_target_o,
//   sp_address_o                      scratchpad read port
//   sp_write_enable_i, sp_data_i      scratchpad contention / read data
//   data_o, valid_o, ready_i, last_o  output stream
module sp_reader
    import matmul_pkg::*;
#(
    parameter int unsigned SP_NTARGETS = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BUS_WIDTH   = 64,
    localparam int unsigned MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int unsigned CW         = $clog2(MAX_DIM),
    localparam int unsigned AW         = calc_aw(MAX_DIM)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [SP_TGT_W-1:0]  target_i,
    input  logic [CW-1:0]        rows_m1_i,
    input  logic [CW-1:0]        cols_m1_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 sp_mode_o,
    output logic [SP_TGT_W-1:0]  sp_read_target_o,
    output logic [AW-1:0]        sp_address_o,
    input  logic                 sp_write_enable_i,
    input  logic [BUS_WIDTH-1:0] sp_data_i,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 last_o
);

    // Elaboration-time sanity on the configuration.
    if (SP_NTARGETS > (1 << SP_TGT_W)) begin : g_bad_ntargets
        $error("sp_reader: SP_NTARGETS does not fit the target select width");
    end
    if (MAX_DIM < 2) begin : g_bad_dim
        $error("sp_reader: BUS_WIDTH must hold at least two elements");
    end

    sp_rd_state_t        state_q, state_d;
    logic [SP_TGT_W-1:0] tgt_q, tgt_d;
    logic [CW-1:0]       rows_q, rows_d, cols_q, cols_d;
    logic [CW-1:0]       row_q, row_d, col_q, col_d;
    logic [AW-1:0]       addr_q;
    logic                busy_q, done_q, mode_q;

    logic                load, flush, slot_free, is_final;

    assign is_final = (row_q == rows_q) && (col_q == cols_q);

    // Next-state, counter and output-stage control.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        row_d   = row_q;
        col_d   = col_q;
        load    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    tgt_d   = target_i;
                    rows_d  = rows_m1_i;
                    cols_d  = cols_m1_i;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (slot_free && !sp_write_enable_i) begin
                    load = 1'b1;
                    if (col_q == cols_q) begin
                        col_d = '0;
                        row_d = row_q + CW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                    if (is_final) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort_i) begin
                    flush   = 1'b1;
                    state_d = IDLE;
                end else if (valid_o && ready_i && last_o) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                flush   = abort_i;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, setup and registered status / read-port outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= AW'(row_d) * AW'(MAX_DIM) + AW'(col_d);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
            mode_q  <= (state_d == READ);
        end
    end

    sp_rd_out_stage #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_out (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .flush     (flush),
        .load      (load),
        .load_data (sp_data_i),
        .load_last (is_final),
        .ready_i   (ready_i),
        .valid     (valid_o),
        .data      (data_o),
        .last      (last_o),
        .slot_free (slot_free)
    );

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign sp_mode_o        = mode_q;
    assign sp_read_target_o = tgt_q;
    assign sp_address_o     = addr_q;

endmodule

// File: tb/tb_sp_reader.sv
// Directed bench for sp_reader with MAX_DIM=4 (BUS_WIDTH=64, DATA_WIDTH=16).
// The scratchpad model returns {8'hC0, 0, target, 0, address} and zero
// while written.
module tb_sp_reader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, abort_i;
    logic [1:0]  target_i, rows_m1_i, cols_m1_i;
    logic        busy_o, done_o, sp_mode_o;
    logic [1:0]  sp_read_target_o;
    logic [3:0]  sp_address_o;
    logic        sp_write_enable_i;
    logic [63:0] sp_data_i, data_o;
    logic        valid_o, ready_i, last_o;

    int checks   = 0;
    int failures = 0;

    logic [63:0] bdata [32];
    logic        blast [32];
    int          bk    [32];
    int          nbeats, ndone, done_k, nlast, nstall, stall_viol, addr_viol;

    always #5 clk_i = ~clk_i;

    sp_reader #(
        .SP_NTARGETS (4),
        .DATA_WIDTH  (16),
        .BUS_WIDTH   (64)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .target_i          (target_i),
        .rows_m1_i         (rows_m1_i),
        .cols_m1_i         (cols_m1_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .sp_mode_o         (sp_mode_o),
        .sp_read_target_o  (sp_read_target_o),
        .sp_address_o      (sp_address_o),
        .sp_write_enable_i (sp_write_enable_i),
        .sp_data_i         (sp_data_i),
        .data_o            (data_o),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .last_o            (last_o)
    );

    assign sp_data_i = sp_write_enable_i ? 64'd0
                     : {8'hC0, 46'd0, sp_read_target_o, 4'd0, sp_address_o};

    function automatic logic [63:0] expd(input logic [1:0] t, input int a);
        return {8'hC0, 46'd0, t, 8'(a)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [1:0] t, input logic [1:0] r, input logic [1:0] c);
        target_i  = t;
        rows_m1_i = r;
        cols_m1_i = c;
        start_i   = 1'b1;
        cyc();
        start_i   = 1'b0;
    endtask

    // Runs ncyc cycles, driving ready from rpat and write-enable over a
    // window, recording accepted beats, done pulses and stability violations.
    task automatic collect(input int ncyc, input logic [3:0] rpat,
                           input int we_from, input int we_len);
        logic [63:0] pdata;
        logic        plast, pvalid, pready, pwe;
        logic [3:0]  paddr;
        nbeats = 0; ndone = 0; done_k = -1; nlast = 0; nstall = 0;
        stall_viol = 0; addr_viol = 0;
        pvalid = 1'b0; pready = 1'b1; pwe = 1'b0; pdata = '0; plast = 1'b0; paddr = '0;
        for (int k = 0; k < ncyc; k++) begin
            ready_i           = rpat[k[1:0]];
            sp_write_enable_i = (k >= we_from) && (k < we_from + we_len);
            if (pvalid && !pready) begin
                nstall++;
                if (!(valid_o === 1'b1 && data_o === pdata && last_o === plast)) stall_viol++;
            end
            if (pwe && sp_address_o !== paddr) addr_viol++;
            if (valid_o && ready_i) begin
                if (nbeats < 32) begin
                    bdata[nbeats] = data_o;
                    blast[nbeats] = last_o;
                    bk[nbeats]    = k;
                end
                if (last_o) nlast++;
                nbeats++;
            end
            if (done_o) begin
                ndone++;
                done_k = k;
            end
            pvalid = valid_o; pready = ready_i; pdata = data_o;
            plast = last_o; pwe = sp_write_enable_i; paddr = sp_address_o;
            cyc();
        end
        ready_i           = 1'b1;
        sp_write_enable_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pa [6];
        int bp [4];
        pa = '{0, 1, 2, 4, 5, 6};
        bp = '{0, 1, 4, 5};

        // Reset state.
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; target_i = '0;
        rows_m1_i = '0; cols_m1_i = '0; sp_write_enable_i = 1'b0; ready_i = 1'b1;
        #2;
        chk("rst_busy",  64'(busy_o), 64'(0));
        chk("rst_done",  64'(done_o), 64'(0));
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_mode",  64'(sp_mode_o), 64'(0));
        chk("rst_addr",  64'(sp_address_o), 64'(0));
        chk("rst_data",  data_o, 64'(0));
        repeat (2) cyc();
        rst_ni = 1'b1;
        cyc();
        chk("idle_busy", 64'(busy_o), 64'(0));

        // Full 4x4 read of target 2.
        do_start(2'd2, 2'd3, 2'd3);
        chk("full_busy",  64'(busy_o), 64'(1));
        chk("full_valid0", 64'(valid_o), 64'(0));
        chk("full_mode",  64'(sp_mode_o), 64'(1));
        chk("full_tgt",   64'(sp_read_target_o), 64'(2));
        chk("full_addr0", 64'(sp_address_o), 64'(0));
        collect(24, 4'b1111, 100, 0);
        chk("full_nbeats", 64'(nbeats), 64'(16));
        for (int i = 0; i < 16; i++) chk("full_data", bdata[i], expd(2'd2, i));
        chk("full_nlast", 64'(nlast), 64'(1));
        chk("full_last15", 64'(blast[15]), 64'(1));
        chk("full_first_k", 64'(bk[0]), 64'(1));
        chk("full_last_k", 64'(bk[15]), 64'(16));
        chk("full_ndone", 64'(ndone), 64'(1));
        chk("full_done_k", 64'(done_k), 64'(17));
        chk("full_busy_end", 64'(busy_o), 64'(0));
        chk("full_mode_end", 64'(sp_mode_o), 64'(0));

        // Partial 2x3 read of target 1.
        do_start(2'd1, 2'd1, 2'd2);
        collect(16, 4'b1111, 100, 0);
        chk("part_nbeats", 64'(nbeats), 64'(6));
        for (int i = 0; i < 6; i++) chk("part_data", bdata[i], expd(2'd1, pa[i]));
        chk("part_last5", 64'(blast[5]), 64'(1));
        chk("part_nlast", 64'(nlast), 64'(1));
        chk("part_ndone", 64'(ndone), 64'(1));

        // Backpressure on a 2x2 read with ready pattern 1,0,0,1.
        do_start(2'd0, 2'd1, 2'd1);
        collect(20, 4'b1001, 100, 0);
        chk("bp_nbeats", 64'(nbeats), 64'(4));
        for (int i = 0; i < 4; i++) chk("bp_data", bdata[i], expd(2'd0, bp[i]));
        chk("bp_stalled", 64'(nstall > 0), 64'(1));
        chk("bp_stable", 64'(stall_viol), 64'(0));
        chk("bp_last3", 64'(blast[3]), 64'(1));
        chk("bp_ndone", 64'(ndone), 64'(1));

        // Write contention for 3 cycles mid-read.
        do_start(2'd3, 2'd3, 2'd3);
        collect(30, 4'b1111, 5, 3);
        chk("wc_nbeats", 64'(nbeats), 64'(16));
        for (int i = 0; i < 16; i++) chk("wc_data", bdata[i], expd(2'd3, i));
        chk("wc_addr_frozen", 64'(addr_viol), 64'(0));
        chk("wc_last_k", 64'(bk[15]), 64'(19));
        chk("wc_ndone", 64'(ndone), 64'(1));

        // Single entry, with a start pulse while busy that must be ignored.
        do_start(2'd0, 2'd0, 2'd0);
        target_i = 2'd3; rows_m1_i = 2'd3; cols_m1_i = 2'd3; start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        collect(8, 4'b1111, 100, 0);
        chk("single_nbeats", 64'(nbeats), 64'(1));
        chk("single_data", bdata[0], expd(2'd0, 0));
        chk("single_last", 64'(blast[0]), 64'(1));
        chk("single_ndone", 64'(ndone), 64'(1));
        chk("single_tgt", 64'(sp_read_target_o), 64'(0));
        chk("single_busy", 64'(busy_o), 64'(0));

        // Abort after three accepted beats.
        do_start(2'd2, 2'd3, 2'd3);
        ready_i = 1'b1;
        repeat (4) cyc();
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        chk("abort_valid", 64'(valid_o), 64'(0));
        chk("abort_mode",  64'(sp_mode_o), 64'(0));
        chk("abort_busy",  64'(busy_o), 64'(0));
        chk("abort_done",  64'(done_o), 64'(0));
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            if (done_o) ndone++;
            cyc();
        end
        chk("abort_no_done", 64'(ndone), 64'(0));
        do_start(2'd1, 2'd0, 2'd1);
        collect(8, 4'b1111, 100, 0);
        chk("restart_nbeats", 64'(nbeats), 64'(2));
        chk("restart_data0", bdata[0], expd(2'd1, 0));
        chk("restart_data1", bdata[1], expd(2'd1, 1));
        chk("restart_ndone", 64'(ndone), 64'(1));

        // Asynchronous reset mid-stream.
        do_start(2'd2, 2'd3, 2'd3);
        repeat (3) cyc();
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(valid_o), 64'(0));
        chk("arst_busy",  64'(busy_o), 64'(0));
        chk("arst_mode",  64'(sp_mode_o), 64'(0));
        chk("arst_addr",  64'(sp_address_o), 64'(0));
        chk("arst_data",  data_o, 64'(0));
        chk("arst_last",  64'(last_o), 64'(0));
        chk("arst_tgt",   64'(sp_read_target_o), 64'(0));
        chk("arst_done",  64'(done_o), 64'(0));
        cyc();
        rst_ni = 1'b1;
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            if (done_o) ndone++;
            cyc();
        end
        chk("arst_no_done", 64'(ndone), 64'(0));
        chk("arst_idle", 64'(busy_o), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
